icache_responder: RTL and testbench
===================================

# icache_responder

Direct-mapped, read-only instruction cache that sits on the responder side of the core's instruction-fetch port (`imem_req`/`imem_addr` in, `imem_rdata`/`imem_valid` out). Hits return one cycle after the request. Misses refill a full line from a backing word-wide memory port, then answer. It lives between the fetch stage of each core and the shared instruction memory / interconnect.

## Interface
- `ADDR_WIDTH`, 32, byte-address width (from `pkg_opengpu`)
- `INSTR_WIDTH`, 32, instruction width (from `pkg_opengpu`)
- `NUM_LINES`, 16, cache lines; power of two, ≥2
- `WORDS_PER_LINE`, 4, 32-bit words per line; power of two, ≥2
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `imem_req`  in  1  fetch request, single-cycle pulse
- `imem_addr`  in  ADDR_WIDTH  fetch byte address, sampled only when `imem_req`=1
- `imem_flush`  in  1  cancel any outstanding response (pipeline flush)
- `invalidate`  in  1  clear all line valid bits
- `imem_rdata`  out  INSTR_WIDTH  instruction, meaningful only with `imem_valid`
- `imem_valid`  out  1  response pulse, one cycle per accepted request
- `busy`  out  1  high in any state other than IDLE
- `mem_req`  out  1  backing-memory word request, single-cycle pulse
- `mem_addr`  out  ADDR_WIDTH  backing word byte address, held until `mem_valid`
- `mem_rdata`  in  INSTR_WIDTH  backing read data
- `mem_valid`  in  1  backing read-data strobe, one per `mem_req`

## Operation
- Address split: bits [1:0] are ignored. Word offset is log2(WORDS_PER_LINE) bits, then index is log2(NUM_LINES) bits, then tag is the rest.
- Storage: per line, one valid bit, a tag and WORDS_PER_LINE data words, all in flops. Reset and `invalidate` clear only the valid bits.
- States: IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, RESPOND.
- IDLE: when `imem_req`=1 and `imem_flush`=0, latch the address and go to LOOKUP. `imem_req` together with `imem_flush` is dropped.
- LOOKUP, hit (line valid and tag matches): `imem_valid`=1 with the selected word, then go to IDLE.
- LOOKUP, miss: set word counter k=0, clear the line's valid bit, go to REFILL_REQ.
- REFILL_REQ: `mem_req`=1 for one cycle, `mem_addr`=line base + 4k, then go to REFILL_WAIT.
- REFILL_WAIT: on `mem_valid`, write word k. If k=WORDS_PER_LINE-1, write the tag, set valid and go to RESPOND. Otherwise k++ and go to REFILL_REQ.
- RESPOND: `imem_valid`=1 with the requested word (critical word is not forwarded early), then go to IDLE.
- Cancel: `imem_flush` in any non-IDLE state sets a `cancelled` flag. A cancelled request still completes its refill, because backing memory cannot abort, but no `imem_valid` is produced. The flag clears on return to IDLE.
- `imem_req` outside IDLE is ignored. The fetch stage never issues one while a response is owed.
- `invalidate` in IDLE clears the valid bits at the next edge.
- `invalidate` while busy is recorded and applied on the cycle the FSM enters IDLE, after the current response. It has priority over a same-cycle `imem_req`: the request is still accepted, and its lookup sees invalidated lines.
- `mem_valid` in any state other than REFILL_WAIT is ignored.

## Timing
- Reset values: state IDLE; `imem_valid`=0, `imem_rdata`=0, `mem_req`=0, `mem_addr`=0, `busy`=0; all valid bits 0; cancel and invalidate-pending flags 0.
- All outputs are registered or decoded from state and registers only. There is no combinational path from `imem_req` to `imem_valid`.
- Hit: request at edge N, `imem_valid` high during cycle N+1. Back-to-back hits are accepted every 2 cycles (IDLE→LOOKUP→IDLE).
- Miss: 2 + Σ(REFILL_REQ 1 + memory latency Lk) + 1 cycles from request to `imem_valid`. With Lk=1 that is 4·2+3 = 11 cycles.
- `mem_req` is never re-asserted before the prior `mem_valid` arrives. At most one backing request is outstanding.
- `rst` mid-refill: return to IDLE immediately and invalidate the partially filled line. A later `mem_valid` is ignored.

## Test plan
- Cold miss, then hit: reset; req 0x100 with memory returning 0xA0+k after 1 cycle. Expect `mem_addr` sequence 0x100, 0x104, 0x108, 0x10C and `imem_valid` with 0xA0 at cycle 11. Then req 0x108: expect 0xA2 one cycle later and no `mem_req`.
- Conflict eviction (16 lines × 16 B): fill 0x000, then req 0x100 (same index, different tag) triggers a refill. Req 0x000 must then miss again.
- Flush during refill: req 0x200, assert `imem_flush` in the second REFILL_WAIT. All 4 `mem_req` must still complete, no `imem_valid` is produced, and a later req 0x204 hits.
- Invalidate while busy: during a refill, pulse `invalidate`. The refill's response is delivered, then any request to the same line misses.
- Request with flush: `imem_req` and `imem_flush` in the same cycle produce no state change and no `imem_valid`. Low address bits: req 0x103 returns the same word as 0x100.
- Reset mid-refill: assert `rst` after 2 words, then deliver a stray `mem_valid`. Expect no response, `busy`=0, and a req to the same line misses.

Source files
------------

// File: rtl/icache_responder.sv
// icache_responder: direct-mapped read-only instruction cache with word-by-word line refill
module icache_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int INSTR_WIDTH    = 32,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   imem_req,
  input  logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_flush,
  input  logic                   invalidate,
  output logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   imem_valid,
  output logic                   busy,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  input  logic                   mem_valid
);
  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = ADDR_WIDTH - 2 - OW - IW;
  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, RESPOND} state_t;
  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-3:0]  addr_q, addr_d;
  logic [OW-1:0]          k_q, k_d;
  logic                   cancel_q, cancel_d, inv_pend_q, inv_pend_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic [TW-1:0]          tag_q [NUM_LINES];
  logic [INSTR_WIDTH-1:0] data_q [NUM_LINES][WORDS_PER_LINE];
  logic [OW-1:0]          off;
  logic [IW-1:0]          idx;
  logic [TW-1:0]          tag;
  logic                   hit, fill, last, unused_lsb;
  assign off        = addr_q[OW-1:0];
  assign idx        = addr_q[OW+:IW];
  assign tag        = addr_q[ADDR_WIDTH-3-:TW];
  assign hit        = valid_q[idx] && tag_q[idx] == tag;
  assign fill       = state_q == REFILL_WAIT && mem_valid;
  assign last       = k_q == OW'(WORDS_PER_LINE - 1);
  assign unused_lsb = ^imem_addr[1:0];
  assign busy       = state_q != IDLE;
  assign mem_req    = state_q == REFILL_REQ;
  assign mem_addr   = mem_addr_q;
  assign imem_valid = !cancel_q && (state_q == RESPOND || (state_q == LOOKUP && hit));
  assign imem_rdata = imem_valid ? data_q[idx][off] : '0;
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    k_d        = k_q;
    valid_d    = valid_q;
    cancel_d   = state_q != IDLE && (cancel_q || imem_flush);
    inv_pend_d = state_q != IDLE && (inv_pend_q || invalidate);
    // a deferred invalidate lands before the lookup of a request accepted this cycle
    if (state_q == IDLE && (invalidate || inv_pend_q)) valid_d = '0;
    case (state_q)
      IDLE: if (imem_req && !imem_flush) begin
        state_d = LOOKUP;
        addr_d  = imem_addr[ADDR_WIDTH-1:2];
      end
      LOOKUP: if (hit) state_d = IDLE;
      else begin
        state_d      = REFILL_REQ;
        k_d          = '0;
        valid_d[idx] = 1'b0;
      end
      REFILL_REQ: state_d = REFILL_WAIT;
      REFILL_WAIT: if (mem_valid) begin
        state_d      = last ? RESPOND : REFILL_REQ;
        k_d          = last ? k_q : k_q + OW'(1);
        valid_d[idx] = last;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_addr_d = state_d == REFILL_REQ ? {addr_q[ADDR_WIDTH-3:OW], k_d, 2'b00} : mem_addr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      k_q        <= '0;
      cancel_q   <= 1'b0;
      inv_pend_q <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      k_q        <= k_d;
      cancel_q   <= cancel_d;
      inv_pend_q <= inv_pend_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[idx][k_q] <= mem_rdata;
      if (last) tag_q[idx] <= tag;
    end
  end
endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: scoreboard bench with a 1-cycle-latency backing memory model
module tb_icache_responder;
  logic        clk = 0, rst = 1;
  logic        imem_req = 0, imem_flush = 0, invalidate = 0;
  logic [31:0] imem_addr = 0;
  logic [31:0] imem_rdata, mem_addr, mem_rdata;
  logic        imem_valid, busy, mem_req, mem_valid;
  int          n_tests = 0, n_fail = 0, cyc = 0, rsp_cyc = 0, mem_reqs = 0, mem_budget = 1000000;
  logic [31:0] rsp_q[$], mem_q[$];
  logic        pend = 0;
  logic [31:0] pend_a = 0;

  icache_responder dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_flush(imem_flush), .invalidate(invalidate), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h60 + (a >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    logic [31:0] e;
    mem_valid = 0;
    mem_rdata = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_valid = 0;
      if (pend && mem_budget > 0) begin
        mem_valid = 1;
        mem_rdata = mem_word(pend_a);
        pend = 0;
        mem_budget--;
      end
      if (mem_req) begin
        mem_reqs++;
        chk("mem_outstanding", {31'd0, pend}, 0);
        e = mem_q.size() > 0 ? mem_q.pop_front() : 32'hDEADBEEF;
        chk("mem_addr", mem_addr, e);
        pend = 1;
        pend_a = mem_addr;
      end
    end
  end

  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (imem_valid) begin
        rsp_cyc = cyc;
        e = rsp_q.size() > 0 ? rsp_q.pop_front() : 32'hDEADBEEF;
        chk("rdata", imem_rdata, e);
      end
    end
  end

  task automatic wait_idle();
    int i = 0;
    do begin
      @(posedge clk);
      #1;
      i++;
    end while (busy && i < 60);
    chk("idle", {31'd0, busy}, 0);
  endtask

  task automatic fetch(input logic [31:0] a, input bit hit, input bit flush2, input bit inv2);
    int t0, base;
    @(negedge clk);
    imem_req = 1;
    imem_addr = a;
    t0 = cyc;
    base = mem_reqs;
    if (!flush2) rsp_q.push_back(mem_word(a));
    if (!hit) for (int k = 0; k < 4; k++) mem_q.push_back({a[31:4], 4'h0} + 32'(4 * k));
    @(negedge clk);
    imem_req = 0;
    if (flush2 || inv2) begin
      for (int i = 0; i < 40 && mem_reqs < base + 2; i++) @(negedge clk);
      @(negedge clk);
      imem_flush = flush2;
      invalidate = inv2;
      @(negedge clk);
      imem_flush = 0;
      invalidate = 0;
    end
    wait_idle();
    if (!flush2) chk(hit ? "hit_lat" : "miss_lat", rsp_cyc - t0 + 1, hit ? 2 : 11);
    chk("mem_left", mem_q.size(), 0);
    chk("rsp_left", rsp_q.size(), 0);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, imem_valid}, 0);
    chk("rst_rdata", imem_rdata, 0);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst = 0;
    fetch(32'h100, 0, 0, 0);
    fetch(32'h108, 1, 0, 0);
    fetch(32'h000, 0, 0, 0);
    fetch(32'h004, 1, 0, 0);
    fetch(32'h100, 0, 0, 0);
    fetch(32'h000, 0, 0, 0);
    fetch(32'h200, 0, 1, 0);
    fetch(32'h204, 1, 0, 0);
    fetch(32'h410, 0, 0, 1);
    fetch(32'h41C, 0, 0, 0);
    fetch(32'h204, 0, 0, 0);
    @(negedge clk);
    imem_req = 1;
    imem_flush = 1;
    imem_addr = 32'h100;
    @(negedge clk);
    imem_req = 0;
    imem_flush = 0;
    chk("drop_busy", {31'd0, busy}, 0);
    fetch(32'h100, 0, 0, 0);
    fetch(32'h103, 1, 0, 0);
    chk("low_bits_word", mem_word(32'h103), 32'hA0);
    // reset after two words, then let the held third word arrive as a stray strobe
    mem_budget = 2;
    @(negedge clk);
    imem_req = 1;
    imem_addr = 32'h300;
    base = mem_reqs;
    for (int k = 0; k < 3; k++) mem_q.push_back(32'h300 + 32'(4 * k));
    @(negedge clk);
    imem_req = 0;
    for (int i = 0; i < 40 && mem_reqs < base + 3; i++) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    mem_budget = 1;
    repeat (3) @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    chk("rst_mid_pend", {31'd0, pend}, 0);
    mem_budget = 1000000;
    fetch(32'h304, 0, 0, 0);
    fetch(32'h308, 1, 0, 0);
    @(negedge clk);
    invalidate = 1;
    @(negedge clk);
    invalidate = 0;
    fetch(32'h30C, 0, 0, 0);
    repeat (4) @(negedge clk);
    chk("end_rsp_q", rsp_q.size(), 0);
    chk("end_mem_q", mem_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
